// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI4 burst master with independent write and read engines.
// Latency: AxVALID one cycle after start; write data and read data pass combinationally; done pulses one cycle after the final handshake.
// Backpressure: the master waits indefinitely on AWREADY/WREADY/BVALID/ARREADY/RVALID and holds every output steady while stalled.
//
// Ports:
//   ACLK, ARESETn                      clock, asynchronous active-low reset
//   AW*/W*/B*                          AXI write address, write data, write response
//   AR*/R*                             AXI read address, read data
//   i_wr_start/i_wr_addr/i_wr_len      write command (len = beats-1)
//   i_wr_data, o_wr_pop                write data source; pop marks the accepted beat
//   i_rd_start/i_rd_addr/i_rd_len      read command (len = beats-1)
//   o_rd_data, o_rd_valid              read beats delivered to the user
//   o_wr_busy/o_rd_busy/o_wr_done/o_rd_done/o_err   status
//
// Build option: define AXI_MASTER_RESP_CHECK_EN to raise a sticky o_err on
// non-OKAY responses or an RLAST that disagrees with the requested length.
// Without it o_err is constant 0 and response codes are ignored.
module axi_master #(
  parameter int M_ID_BW   = 4,
  parameter int M_ADDR_BW = 32,
  parameter int M_DATA_BW = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  // write address
  output logic [M_ID_BW-1:0]     AWID,
  output logic [M_ADDR_BW-1:0]   AWADDR,
  output logic [7:0]             AWLEN,
  output logic [2:0]             AWSIZE,
  output logic [1:0]             AWBURST,
  output logic                   AWVALID,
  input  logic                   AWREADY,
  // write data
  output logic [M_DATA_BW-1:0]   WDATA,
  output logic [M_DATA_BW/8-1:0] WSTRB,
  output logic                   WLAST,
  output logic                   WVALID,
  input  logic                   WREADY,
  // write response
  input  logic [M_ID_BW-1:0]     BID,
  input  logic [1:0]             BRESP,
  input  logic                   BVALID,
  output logic                   BREADY,
  // read address
  output logic [M_ID_BW-1:0]     ARID,
  output logic [M_ADDR_BW-1:0]   ARADDR,
  output logic [7:0]             ARLEN,
  output logic [2:0]             ARSIZE,
  output logic [1:0]             ARBURST,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  // read data
  input  logic [M_ID_BW-1:0]     RID,
  input  logic [M_DATA_BW-1:0]   RDATA,
  input  logic [1:0]             RRESP,
  input  logic                   RLAST,
  input  logic                   RVALID,
  output logic                   RREADY,
  // user write command
  input  logic                   i_wr_start,
  input  logic [M_ADDR_BW-1:0]   i_wr_addr,
  input  logic [7:0]             i_wr_len,
  input  logic [M_DATA_BW-1:0]   i_wr_data,
  output logic                   o_wr_pop,
  // user read command
  input  logic                   i_rd_start,
  input  logic [M_ADDR_BW-1:0]   i_rd_addr,
  input  logic [7:0]             i_rd_len,
  output logic [M_DATA_BW-1:0]   o_rd_data,
  output logic                   o_rd_valid,
  // status
  output logic                   o_wr_busy,
  output logic                   o_rd_busy,
  output logic                   o_wr_done,
  output logic                   o_rd_done,
  output logic                   o_err
);

  localparam logic [2:0] BEAT_SIZE = 3'($clog2(M_DATA_BW / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t               w_state, w_next;
  r_state_t               r_state, r_next;
  logic [M_ADDR_BW-1:0]   wr_addr_q, rd_addr_q;
  logic [7:0]             wr_len_q, rd_len_q;
  logic [7:0]             wr_cnt;
  logic                   w_hs, b_hs, r_hs;

  assign w_hs = WVALID & WREADY;
  assign b_hs = BVALID & BREADY;
  assign r_hs = RVALID & RREADY;

  // ---------------- write engine ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      wr_cnt    <= '0;
      o_wr_done <= 1'b0;
    end else begin
      w_state   <= w_next;
      o_wr_done <= b_hs;
      if (w_state == W_IDLE && i_wr_start) begin
        wr_addr_q <= i_wr_addr;
        wr_len_q  <= i_wr_len;
        wr_cnt    <= '0;
      end else if (w_hs) begin
        wr_cnt    <= wr_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (i_wr_start)         w_next = W_ADDR;
      W_ADDR: if (AWREADY)            w_next = W_DATA;
      W_DATA: if (w_hs && WLAST)      w_next = W_RESP;
      W_RESP: if (BVALID)             w_next = W_IDLE;
      default:                        w_next = W_IDLE;
    endcase
  end

  assign AWID     = '0;
  assign AWADDR   = wr_addr_q;
  assign AWLEN    = wr_len_q;
  assign AWSIZE   = BEAT_SIZE;
  assign AWBURST  = BURST_INCR;
  assign AWVALID  = (w_state == W_ADDR);
  assign WDATA    = i_wr_data;
  assign WSTRB    = '1;
  assign WVALID   = (w_state == W_DATA);
  // Counter holds the index of the beat currently presented, so the last
  // beat is the one whose index equals the requested len.
  assign WLAST    = (w_state == W_DATA) && (wr_cnt == wr_len_q);
  assign BREADY   = (w_state == W_RESP);
  assign o_wr_pop = w_hs;
  assign o_wr_busy = (w_state != W_IDLE);

  // ---------------- read engine ----------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      o_rd_done <= 1'b0;
    end else begin
      r_state   <= r_next;
      o_rd_done <= r_hs & RLAST;
      if (r_state == R_IDLE && i_rd_start) begin
        rd_addr_q <= i_rd_addr;
        rd_len_q  <= i_rd_len;
      end
    end
  end

  // Termination follows RLAST only; the requested length never ends a burst.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (i_rd_start)         r_next = R_ADDR;
      R_ADDR: if (ARREADY)            r_next = R_DATA;
      R_DATA: if (RVALID && RLAST)    r_next = R_IDLE;
      default:                        r_next = R_IDLE;
    endcase
  end

  assign ARID       = '0;
  assign ARADDR     = rd_addr_q;
  assign ARLEN      = rd_len_q;
  assign ARSIZE     = BEAT_SIZE;
  assign ARBURST    = BURST_INCR;
  assign ARVALID    = (r_state == R_ADDR);
  assign RREADY     = (r_state == R_DATA);
  assign o_rd_data  = RDATA;
  assign o_rd_valid = r_hs;
  assign o_rd_busy  = (r_state != R_IDLE);

  // ---------------- response checking ----------------
`ifdef AXI_MASTER_RESP_CHECK_EN
  logic [7:0] rd_cnt;
  logic       err_q;
  logic       rlast_bad;

  // RLAST must coincide exactly with the beat whose index equals len.
  assign rlast_bad = RLAST != (rd_cnt == rd_len_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (r_state == R_IDLE && i_rd_start) rd_cnt <= '0;
      else if (r_hs)                       rd_cnt <= rd_cnt + 8'd1;
      if ((b_hs && BRESP != 2'b00) || (r_hs && (RRESP != 2'b00 || rlast_bad)))
        err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // IDs are never checked (single outstanding, ID always 0); response codes
  // are only consumed when checking is built in.
  logic unused_ok;
  assign unused_ok = &{1'b0, BID, RID, BRESP, RRESP};

endmodule

// File: tb/tb_axi_master.sv
module tb_axi_master;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic [IDW-1:0] AWID, ARID, BID, RID;
  logic [AW-1:0]  AWADDR, ARADDR;
  logic [7:0]     AWLEN, ARLEN;
  logic [2:0]     AWSIZE, ARSIZE;
  logic [1:0]     AWBURST, ARBURST, BRESP, RRESP;
  logic           AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic           ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0]  WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic           i_wr_start, i_rd_start, o_wr_pop, o_rd_valid;
  logic [AW-1:0]  i_wr_addr, i_rd_addr;
  logic [7:0]     i_wr_len, i_rd_len;
  logic [DW-1:0]  i_wr_data, o_rd_data;
  logic           o_wr_busy, o_rd_busy, o_wr_done, o_rd_done, o_err;

  axi_master #(.M_ID_BW(IDW), .M_ADDR_BW(AW), .M_DATA_BW(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .i_wr_start(i_wr_start), .i_wr_addr(i_wr_addr), .i_wr_len(i_wr_len),
    .i_wr_data(i_wr_data), .o_wr_pop(o_wr_pop),
    .i_rd_start(i_rd_start), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_wr_busy(o_wr_busy), .o_rd_busy(o_rd_busy), .o_wr_done(o_wr_done),
    .o_rd_done(o_rd_done), .o_err(o_err)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- test configuration (written by the sequencer only) ----
  logic [AW-1:0] exp_waddr = '0, exp_raddr = '0;
  logic [7:0]    exp_wlen = '0, exp_rlen = '0;
  logic [DW-1:0] wbase = 32'hA000_0000;
  logic [DW-1:0] rbase = 32'hDEAD_BEEF;
  bit            wmode_toggle = 1'b0;
  logic [1:0]    bresp_val = 2'b00;

  // ---- handshake flags and model state (written by the monitor only) ----
  bit aw_acc, w_acc, b_acc, ar_acc, r_acc;
  bit prev_b_acc, prev_rlast_acc, prev_wvalid, prev_wrdy;
  logic [DW-1:0] prev_wdata;
  bit            prev_wlast;
  int wbeat = 0, rbeat = 0, wpop_n = 0, wlast_n = 0;
  int wdone_n = 0, rdone_n = 0, aw_n = 0, ar_n = 0;
  logic [AW-1:0] last_awaddr = '0;
  logic [7:0]    last_awlen = '0;
  logic [DW-1:0] last_rdata = '0;

  // Write-side slave plus user data source: data for beat k is wbase+k and
  // only advances when the master pops a beat.
  int widx = 0;
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0; i_wr_data = wbase;
    forever begin
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; widx = 0;
      end else begin
        AWREADY = 1;
        WREADY  = wmode_toggle ? ~WREADY : 1'b1;
        BVALID  = BREADY;
        BRESP   = bresp_val;
        if (aw_acc) widx = 0;
        else if (w_acc) widx++;
      end
      i_wr_data = wbase + DW'(widx);
    end
  end

  // Read-side slave: returns len+1 beats of rbase+k with RLAST on the last.
  int ridx = 0;
  initial begin
    ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = 0; RRESP = 0; RID = 0;
    forever begin
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        ARREADY = 0; RVALID = 0; RLAST = 0; ridx = 0;
      end else begin
        ARREADY = 1;
        if (ar_acc) ridx = 0;
        else if (r_acc) ridx++;
        if (RREADY && ridx <= int'(exp_rlen)) begin
          RVALID = 1; RDATA = rbase + DW'(ridx); RLAST = (ridx == int'(exp_rlen));
        end else begin
          RVALID = 0; RLAST = 0;
        end
      end
    end
  end

  // Compare process: checks DUT outputs against the burst model every cycle.
  initial begin
    forever begin
      @(negedge ACLK);
      aw_acc = ARESETn && AWVALID && AWREADY;
      w_acc  = ARESETn && WVALID && WREADY;
      b_acc  = ARESETn && BVALID && BREADY;
      ar_acc = ARESETn && ARVALID && ARREADY;
      r_acc  = ARESETn && RVALID && RREADY;
      if (!ARESETn) begin
        prev_b_acc = 0; prev_rlast_acc = 0; prev_wvalid = 0; prev_wrdy = 0;
      end else begin
        if (aw_acc) begin
          chk("aw_addr", AWADDR, exp_waddr);
          chk("aw_len", AWLEN, exp_wlen);
          chk("aw_size", AWSIZE, 3'd2);
          chk("aw_burst", AWBURST, 2'b01);
          chk("aw_id", AWID, 0);
          last_awaddr = AWADDR; last_awlen = AWLEN;
          wbeat = 0; wpop_n = 0; wlast_n = 0; aw_n++;
        end
        chk("wr_pop", o_wr_pop, w_acc);
        if (WVALID) chk("wstrb", WSTRB, 4'hF);
        if (WVALID && prev_wvalid && !prev_wrdy) begin
          chk("wdata_hold", WDATA, prev_wdata);
          chk("wlast_hold", WLAST, prev_wlast);
        end
        if (w_acc) begin
          chk("wdata", WDATA, wbase + DW'(wbeat));
          chk("wlast", WLAST, wbeat == int'(exp_wlen));
          if (WLAST) wlast_n++;
          wbeat++; wpop_n++;
        end
        chk("wr_done", o_wr_done, prev_b_acc);
        if (o_wr_done) begin
          wdone_n++;
          chk("wr_beats_at_done", wbeat, int'(exp_wlen) + 1);
        end
        if (ar_acc) begin
          chk("ar_addr", ARADDR, exp_raddr);
          chk("ar_len", ARLEN, exp_rlen);
          chk("ar_size", ARSIZE, 3'd2);
          chk("ar_burst", ARBURST, 2'b01);
          chk("ar_id", ARID, 0);
          rbeat = 0; ar_n++;
        end
        chk("rd_valid", o_rd_valid, r_acc);
        if (r_acc) begin
          chk("rd_data", o_rd_data, rbase + DW'(rbeat));
          last_rdata = o_rd_data;
          rbeat++;
        end
        chk("rd_done", o_rd_done, prev_rlast_acc);
        if (o_rd_done) rdone_n++;
        prev_b_acc = b_acc;
        prev_rlast_acc = r_acc && RLAST;
        prev_wvalid = WVALID; prev_wrdy = WREADY; prev_wdata = WDATA; prev_wlast = WLAST;
      end
    end
  end

  task automatic start_wr(input logic [AW-1:0] a, input logic [7:0] l);
    @(posedge ACLK); #1;
    exp_waddr = a; exp_wlen = l;
    i_wr_addr = a; i_wr_len = l; i_wr_start = 1;
    @(posedge ACLK); #1;
    i_wr_start = 0;
  endtask

  task automatic start_rd(input logic [AW-1:0] a, input logic [7:0] l);
    @(posedge ACLK); #1;
    exp_raddr = a; exp_rlen = l;
    i_rd_addr = a; i_rd_len = l; i_rd_start = 1;
    @(posedge ACLK); #1;
    i_rd_start = 0;
  endtask

  task automatic wait_wdone(input int target);
    int n = 0;
    while (wdone_n < target && n < 400) begin @(negedge ACLK); n++; end
    repeat (3) @(negedge ACLK);
    chk("wr_done_count", wdone_n, target);
  endtask

  task automatic wait_rdone(input int target);
    int n = 0;
    while (rdone_n < target && n < 400) begin @(negedge ACLK); n++; end
    repeat (3) @(negedge ACLK);
    chk("rd_done_count", rdone_n, target);
  endtask

  bit exp_err;
  int aw_before, wd_before;

  initial begin
`ifdef AXI_MASTER_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    i_wr_start = 0; i_rd_start = 0; i_wr_addr = 0; i_wr_len = 0; i_rd_addr = 0; i_rd_len = 0;
    repeat (3) @(negedge ACLK);
    // reset state
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wlast", WLAST, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_arlen", ARLEN, 0);
    chk("rst_busy", {o_wr_busy, o_rd_busy}, 0);
    chk("rst_pulses", {o_wr_done, o_rd_done, o_err}, 0);
    @(posedge ACLK); #1 ARESETn = 1;

    // basic 4-beat write
    start_wr(32'h100, 8'd3);
    @(negedge ACLK);
    chk("wr_busy_after_start", o_wr_busy, 1);
    wait_wdone(1);
    chk("t36_awaddr", last_awaddr, 32'h100);
    chk("t36_awlen", last_awlen, 8'd3);
    chk("t36_pops", wpop_n, 4);
    chk("t36_wlast_once", wlast_n, 1);
    chk("t36_idle", o_wr_busy, 0);

    // same write with WREADY toggling
    wmode_toggle = 1;
    start_wr(32'h100, 8'd3);
    wait_wdone(2);
    chk("t37_pops", wpop_n, 4);
    chk("t37_wlast_once", wlast_n, 1);
    wmode_toggle = 0;

    // single-beat read
    rbase = 32'hDEAD_BEEF;
    start_rd(32'h200, 8'd0);
    wait_rdone(1);
    chk("t38_beats", rbeat, 1);
    chk("t38_data", last_rdata, 32'hDEAD_BEEF);
    chk("t38_rd_idle", o_rd_busy, 0);

    // concurrent 8-beat write and read, plus a start that must be ignored
    rbase = 32'h5000_0000;
    aw_before = aw_n;
    @(posedge ACLK); #1;
    exp_waddr = 32'h800; exp_wlen = 8'd7; i_wr_addr = 32'h800; i_wr_len = 8'd7; i_wr_start = 1;
    exp_raddr = 32'h900; exp_rlen = 8'd7; i_rd_addr = 32'h900; i_rd_len = 8'd7; i_rd_start = 1;
    @(posedge ACLK); #1;
    i_wr_start = 0; i_rd_start = 0;
    repeat (3) @(posedge ACLK);
    #1 i_wr_addr = 32'h999; i_wr_start = 1;
    @(posedge ACLK); #1 i_wr_start = 0;
    wait_wdone(3);
    wait_rdone(2);
    chk("t39_wpops", wpop_n, 8);
    chk("t39_rbeats", rbeat, 8);
    chk("t39_single_aw", aw_n - aw_before, 1);

    // error response
    bresp_val = 2'b10;
    start_wr(32'h180, 8'd1);
    wait_wdone(4);
    chk("t40_err", o_err, exp_err);
    bresp_val = 2'b00;
    start_wr(32'h1C0, 8'd0);
    wait_wdone(5);
    chk("t40_err_sticky", o_err, exp_err);

    // reset in the middle of a write burst
    wd_before = wdone_n;
    start_wr(32'h400, 8'd7);
    begin
      int n = 0;
      while (wbeat < 2 && n < 100) begin @(negedge ACLK); n++; end
    end
    chk("t41_reached_beat2", wbeat, 2);
    @(posedge ACLK); #1 ARESETn = 0;
    #1;
    chk("t41_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, WLAST}, 0);
    chk("t41_busy", o_wr_busy, 0);
    chk("t41_err_clr", o_err, 0);
    chk("t41_awaddr", AWADDR, 0);
    repeat (3) @(negedge ACLK);
    chk("t41_no_done", o_wr_done, 0);
    @(posedge ACLK); #1;
    ARESETn = 1;
    exp_waddr = 32'h300; exp_wlen = 8'd1;
    i_wr_addr = 32'h300; i_wr_len = 8'd1; i_wr_start = 1;
    @(posedge ACLK); #1 i_wr_start = 0;
    wait_wdone(wd_before + 1);
    chk("t41_new_pops", wpop_n, 2);
    chk("t41_new_addr", last_awaddr, 32'h300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
